// File: rtl/sfx_pkg.sv
// Shared types and the default melody table for the sound-effect sequencer.
// A note is one tone (or rest) held for a number of clk cycles.
// SFX_PREEMPT_EN (see sfx_sequencer) does not affect anything in this package.
package sfx_pkg;

    localparam int NOTE_PERIOD_W     = 16;
    localparam int NOTE_DUR_W        = 24;
    localparam int DEF_NUM_SFX       = 4;
    localparam int DEF_NOTES_PER_SFX = 8;

    typedef struct packed {
        logic [NOTE_PERIOD_W-1:0] half_period;  // 0 = rest
        logic [NOTE_DUR_W-1:0]    duration;     // 0 behaves as 1
        logic                     last;
    } note_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } sfx_state_t;

    typedef note_t [DEF_NUM_SFX-1:0][DEF_NOTES_PER_SFX-1:0] sfx_table_t;

    function automatic note_t mk_note(input int unsigned hp, input int unsigned dur, input logic last);
        note_t n;
        n.half_period = NOTE_PERIOD_W'(hp);
        n.duration    = NOTE_DUR_W'(dur);
        n.last        = last;
        return n;
    endfunction

    // Half-periods assume a 50 MHz clk: C5=47801, E5=37936, G5=31888, C6=23900.
    function automatic sfx_table_t build_default_table();
        sfx_table_t t;
        t = '0;
        // 0: jump - quick rising pair
        t[0][0] = mk_note(47801, 2500000, 1'b0);
        t[0][1] = mk_note(37936, 2500000, 1'b1);
        // 1: win - rising arpeggio
        t[1][0] = mk_note(47801, 5000000, 1'b0);
        t[1][1] = mk_note(37936, 5000000, 1'b0);
        t[1][2] = mk_note(31888, 5000000, 1'b0);
        t[1][3] = mk_note(23900, 10000000, 1'b1);
        // 2: lose - falling line with a pause before the final note
        t[2][0] = mk_note(47801, 5000000, 1'b0);
        t[2][1] = mk_note(50619, 5000000, 1'b0);
        t[2][2] = mk_note(0, 2500000, 1'b0);
        t[2][3] = mk_note(63776, 10000000, 1'b1);
        // 3: spare - silent single-cycle rest
        t[3][0] = mk_note(0, 1, 1'b1);
        return t;
    endfunction

    localparam sfx_table_t DEFAULT_TABLE = build_default_table();

endpackage

// File: rtl/sfx_note_rom.sv
// Note table ROM with a registered (one-cycle) read, indexed by effect and note.
module sfx_note_rom
    import sfx_pkg::*;
#(
    parameter int NUM_SFX       = 4,
    parameter int NOTES_PER_SFX = 8,
    parameter note_t [NUM_SFX-1:0][NOTES_PER_SFX-1:0] SFX_TABLE = DEFAULT_TABLE,
    localparam int IDW  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
    localparam int IDXW = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1
) (
    input  logic            clk,
    input  logic [IDW-1:0]  id,
    input  logic [IDXW-1:0] idx,
    output note_t           note
);

    // Synchronous table read.
    always_ff @(posedge clk) begin
        note <= SFX_TABLE[id][idx];
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect engine: edge-detected triggers are latched as pending requests,
// a fixed-priority arbiter (index 0 highest) picks one, and the note sequencer
// plays it as a square wave from the note table.
// Build option: define SFX_PREEMPT_EN to let a higher-priority request abort
// the effect currently loading or playing.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int NUM_SFX       = 4,
    parameter int NOTES_PER_SFX = 8,
    parameter int PERIOD_W      = 16,
    parameter int DUR_W         = 24,
    parameter note_t [NUM_SFX-1:0][NOTES_PER_SFX-1:0] SFX_TABLE = DEFAULT_TABLE,
    localparam int IDW = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SFX-1:0] trig,
    input  logic               mute,
    output logic               sound,
    output logic               busy,
    output logic [IDW-1:0]     active_id,
    output logic               done
);

    localparam int IDXW = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOTES_PER_SFX - 1);

    sfx_state_t          state, state_next;
    logic [NUM_SFX-1:0]  trig_q, rise, pending, pending_next, grant_mask;
    logic [IDW-1:0]      win_id, id_next;
    logic [IDXW-1:0]     note_idx, idx_next;
    logic                grant;
    note_t               rom_note;
    logic [PERIOD_W-1:0] hp_q, tone_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic                last_q, tone;

    assign rise         = trig & ~trig_q;
    assign grant_mask   = grant ? (NUM_SFX'(1) << win_id) : '0;
    // Set wins over the grant clear so a same-cycle re-trigger is kept.
    assign pending_next = (pending & ~grant_mask) | rise;

    // Lowest-index pending request wins.
    always_comb begin
        win_id = '0;
        for (int unsigned i = NUM_SFX; i > 0; i--) begin
            if (pending[i-1]) win_id = IDW'(i - 1);
        end
    end

`ifdef SFX_PREEMPT_EN
    logic [NUM_SFX-1:0] lower_mask;
    logic               preempt;
    assign lower_mask = (NUM_SFX'(1) << active_id) - NUM_SFX'(1);
    assign preempt    = |(pending & lower_mask);
`endif

    // Next state, next table address, grant and done pulse.
    always_comb begin
        state_next = state;
        id_next    = active_id;
        idx_next   = note_idx;
        grant      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_next = LOAD;
                    id_next    = win_id;
                    idx_next   = '0;
                    grant      = 1'b1;
                end
            end
            LOAD: state_next = PLAY;
            PLAY: begin
                if (dur_cnt == '0) begin
                    if (last_q || note_idx == LAST_IDX) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else begin
                        state_next = LOAD;
                        idx_next   = note_idx + IDXW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef SFX_PREEMPT_EN
        if (state != IDLE && preempt) begin
            state_next = LOAD;
            id_next    = win_id;
            idx_next   = '0;
            grant      = 1'b1;
            done       = 1'b0;
        end
`endif
    end

    // The ROM is addressed with the next-cycle index so its data is valid during LOAD.
    sfx_note_rom #(
        .NUM_SFX       (NUM_SFX),
        .NOTES_PER_SFX (NOTES_PER_SFX),
        .SFX_TABLE     (SFX_TABLE)
    ) u_rom (
        .clk  (clk),
        .id   (id_next),
        .idx  (idx_next),
        .note (rom_note)
    );

    // State, edge-detect, pending and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trig_q    <= '0;
            pending   <= '0;
            active_id <= '0;
            note_idx  <= '0;
        end else begin
            state     <= state_next;
            trig_q    <= trig;
            pending   <= pending_next;
            active_id <= id_next;
            note_idx  <= idx_next;
        end
    end

    // Note registers, duration countdown and tone generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q     <= '0;
            last_q   <= 1'b0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (state == LOAD && state_next == PLAY) begin
            hp_q     <= PERIOD_W'(rom_note.half_period);
            last_q   <= rom_note.last;
            dur_cnt  <= (rom_note.duration == '0) ? '0 : DUR_W'(rom_note.duration) - DUR_W'(1);
            tone_cnt <= '0;
            tone     <= (rom_note.half_period != '0);
        end else if (state == PLAY && state_next == PLAY) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (hp_q != '0) begin
                if (tone_cnt == hp_q - PERIOD_W'(1)) begin
                    tone_cnt <= '0;
                    tone     <= ~tone;
                end else begin
                    tone_cnt <= tone_cnt + PERIOD_W'(1);
                end
            end
        end else begin
            dur_cnt  <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
        end
    end

    assign busy  = (state != IDLE);
    assign sound = tone & (state == PLAY) & ~mute;

endmodule
